// File: rtl/led_blinker_pkg.sv
// Shared mode encoding and mode sequencing for the multi-LED blinker.
// BREATHE_MODE_EN selects whether BREATHE takes part in the mode sequence.
package led_blinker_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_BLINK   = 2'd0;
  localparam mode_t MODE_CHASE   = 2'd1;
  localparam mode_t MODE_BREATHE = 2'd2;
  localparam mode_t MODE_ALL_ON  = 2'd3;

  function automatic mode_t next_mode(input mode_t m);
    mode_t n;
    n = m + 2'd1;
`ifndef BREATHE_MODE_EN
    // BREATHE is skipped: CHASE goes directly to ALL_ON
    if (m == MODE_CHASE) n = MODE_ALL_ON;
`endif
    return n;
  endfunction

endpackage

// File: rtl/led_blinker_multi_if.sv
// Board-facing signal bundle of the blinker: raw button in, LEDs and status out.
interface led_blinker_multi_if #(
  parameter int NUM_LEDS = 4
);
  logic                button;
  logic [NUM_LEDS-1:0] leds;
  logic                button_led;
  logic [1:0]          mode;

  modport master (output button, input  leds, button_led, mode);
  modport slave  (input  button, output leds, button_led, mode);
endinterface

// File: rtl/led_blinker_multi_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability counter, level
// register, and a one-cycle pulse on each accepted rising level.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic          level_q, level_d, rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = raw_i;
    sync2_d = sync1_q;
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    // any sample agreeing with the current level restarts the count
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
        rise_d  = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/led_blinker_multi.sv
// Multi-channel LED pattern generator driven by one free-running counter.
// Define BREATHE_MODE_EN to build the PWM BREATHE mode into the sequence.
module led_blinker_multi
  import led_blinker_pkg::*;
#(
  parameter int          NUM_LEDS        = 4,
  parameter int          CNT_WIDTH       = 27,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int          PWM_BITS        = 8
) (
  input logic               clk,
  input logic               rst_n,
  led_blinker_multi_if.slave io
);
  localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  mode_t                mode_q, mode_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic [NUM_LEDS-1:0]  leds_q, leds_d;
  logic                 btn_level, btn_rise, tick;
  logic                 pwm_on;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_i   (io.button),
    .level_o (btn_level),
    .rise_o  (btn_rise)
  );

`ifdef BREATHE_MODE_EN
  logic [PWM_BITS-1:0] ramp, duty;

  if (CNT_WIDTH < 2*PWM_BITS + 1) begin : g_cfg_chk
    $error("led_blinker_multi: CNT_WIDTH must be >= 2*PWM_BITS+1");
  end

  // triangle duty: ramp up in the lower half period, down in the upper half
  assign ramp   = cnt_q[CNT_WIDTH-2 -: PWM_BITS];
  assign duty   = cnt_q[CNT_WIDTH-1] ? ~ramp : ramp;
  assign pwm_on = (cnt_q[PWM_BITS-1:0] < duty);
`else
  assign pwm_on = 1'b0;
`endif

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    tick   = &cnt_q[CNT_WIDTH-2:0];
    mode_d = btn_rise ? next_mode(mode_q) : mode_q;
    pos_d  = pos_q;
    if (btn_rise)
      pos_d = '0;
    else if (tick)
      pos_d = (pos_q == POS_W'(NUM_LEDS - 1)) ? '0 : pos_q + 1'b1;

    leds_d = '0;
    case (mode_q)
      MODE_BLINK: begin
        for (int i = 0; i < NUM_LEDS; i++) leds_d[i] = cnt_q[CNT_WIDTH-1-i];
      end
      MODE_CHASE:   leds_d[pos_q] = 1'b1;
      MODE_BREATHE: leds_d = {NUM_LEDS{pwm_on}};
      MODE_ALL_ON:  leds_d = '1;
      default:      leds_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      mode_q <= MODE_BLINK;
      pos_q  <= '0;
      leds_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      pos_q  <= pos_d;
      leds_q <= leds_d;
    end
  end

  assign io.leds       = leds_q;
  assign io.button_led = btn_level;
  assign io.mode       = mode_q;

endmodule

// File: tb/tb_led_blinker_multi.sv
// Directed bench for led_blinker_multi at CNT_WIDTH=8, NUM_LEDS=4,
// DEBOUNCE_CYCLES=4, PWM_BITS=3; follows the BREATHE_MODE_EN build setting.
module tb_led_blinker_multi;
  localparam int NL = 4;
  localparam int CW = 8;
  localparam int DB = 4;
  localparam int PB = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc;
  int   n_chk = 0;
  int   n_err = 0;

  led_blinker_multi_if #(.NUM_LEDS(NL)) bus ();

  led_blinker_multi #(
    .NUM_LEDS(NL), .CNT_WIDTH(CW), .DEBOUNCE_CYCLES(DB), .PWM_BITS(PB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  always #5 clk = ~clk;

  // edges since reset release == value of the DUT counter
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press();
    bus.button = 1'b1;
    tick(20);
    bus.button = 1'b0;
    tick(20);
  endtask

  // BLINK: led i shows counter bit (7-i)
  function automatic logic [3:0] blink_exp(input int c);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = ((c >> (7 - i)) & 1) != 0;
    return v;
  endfunction

  function automatic logic breathe_on(input int c);
    int r, d;
    r = (c >> 4) & 7;
    d = (c >= 128) ? 7 - r : r;
    return (c & 7) < d;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp;
    bus.button = 1'b0;
    tick(3);
    chk("rst_leds", bus.leds, 0);
    chk("rst_mode", bus.mode, 0);
    chk("rst_bled", bus.button_led, 0);
    rst_n = 1'b1;

    // BLINK from reset; leds lag the counter by one cycle
    for (int k = 1; k <= 512; k++) begin
      tick(1);
      chk("blink_led0", bus.leds[0], ((cyc - 1) / 128) % 2);
      chk("blink_led3", bus.leds[3], ((cyc - 1) / 16) % 2);
      chk("blink_vec", bus.leds, blink_exp((cyc - 1) % 256));
    end

    // short glitch must be rejected
    bus.button = 1'b1;
    tick(3);
    bus.button = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      chk("glitch_bled", bus.button_led, 0);
      chk("glitch_mode", bus.mode, 0);
    end

    // clean press: level after 6 edges, mode one edge later
    bus.button = 1'b1;
    tick(5);
    chk("press_bled_early", bus.button_led, 0);
    tick(1);
    chk("press_bled", bus.button_led, 1);
    chk("press_mode_early", bus.mode, 0);
    tick(1);
    chk("press_mode", bus.mode, 1);
    tick(1);
    chk("chase_entry", bus.leds, 4'b0001);

    // CHASE steps at every 128-cycle tick, button still held
    exp = 4'b0001;
    for (int j = 0; j < 4; j++) begin
      int guard;
      guard = 0;
      do begin
        tick(1);
        guard++;
      end while ((cyc % 128) != 0 && guard < 300);
      chk("chase_wait", guard < 300, 1);
      chk("chase_hold", bus.leds, exp);
      exp = {exp[2:0], exp[3]};
      tick(1);
      chk("chase_step", bus.leds, exp);
      chk("held_mode", bus.mode, 1);
    end

    // release: falling edge does nothing
    bus.button = 1'b0;
    tick(15);
    chk("release_mode", bus.mode, 1);
    chk("release_bled", bus.button_led, 0);

`ifdef BREATHE_MODE_EN
    press();
    chk("seq_breathe", bus.mode, 2);
    for (int k = 0; k < 256; k++) begin
      tick(1);
      chk("breathe", bus.leds, {4{breathe_on((cyc - 1) % 256)}});
    end
`endif
    press();
    chk("seq_all_on", bus.mode, 3);
    chk("all_on_leds", bus.leds, 4'b1111);
    press();
    chk("seq_blink", bus.mode, 0);
    chk("blink_again", bus.leds, blink_exp((cyc - 1) % 256));

    // reset pulse while the button is held
    bus.button = 1'b1;
    tick(10);
    chk("pre_rst_mode", bus.mode, 1);
    chk("pre_rst_bled", bus.button_led, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_leds", bus.leds, 0);
    chk("arst_mode", bus.mode, 0);
    chk("arst_bled", bus.button_led, 0);
    tick(1);
    rst_n = 1'b1;
    tick(6);
    chk("post_rst_mode_early", bus.mode, 0);
    chk("post_rst_bled", bus.button_led, 1);
    tick(1);
    chk("post_rst_mode", bus.mode, 1);
    bus.button = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
